// File: rtl/serial_rx_align.sv
// Serial-to-parallel receiver: locks to byte boundaries on COM_LOCK aligned commas, then emits bytes.
// Latency: data_out/valid_out update on the edge sampling a byte's LSB; no backpressure (bit-synchronous).
module serial_rx_align #(
  parameter logic [7:0] COM      = 8'hBC,
  parameter int         COM_LOCK = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int CW = $clog2(COM_LOCK + 1);
  localparam logic [CW:0] LOCK_N = (CW + 1)'(COM_LOCK);

  localparam logic [1:0] UNALIGNED = 2'd0;
  localparam logic [1:0] ALIGNING  = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  // Only the low 7 shift-register bits ever reach nxt, so the oldest bit is not stored.
  logic [6:0]    sr;
  logic [7:0]    nxt;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] com_cnt;
  logic [CW:0]   com_inc;
  logic [1:0]    state;
  logic          is_com;
  logic          boundary;

  assign nxt      = {sr, data_in};
  assign is_com   = (nxt == COM);
  assign boundary = (bit_cnt == 3'd7);
  assign com_inc  = {1'b0, com_cnt} + 1'b1;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      state     <= UNALIGNED;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= nxt[6:0];
      case (state)
        UNALIGNED: begin
          if (is_com) begin
            bit_cnt <= '0;
            com_cnt <= CW'(1);
            if (COM_LOCK == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGNING;
            end
          end
        end
        ALIGNING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_com) begin
              com_cnt <= (com_inc >= LOCK_N) ? LOCK_N[CW-1:0] : com_inc[CW-1:0];
              if (com_inc == LOCK_N) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              com_cnt <= '0;
              state   <= UNALIGNED;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          // Anything that is not a comma is data, even unexpected values.
          if (boundary) begin
            if (is_com) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= nxt;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= UNALIGNED;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_align.sv
// Directed bench for serial_rx_align: byte tables with expected outputs plus reset and COM_LOCK=1 sequences.
module tb_serial_rx_align;

  typedef struct {
    logic [7:0] b;
    logic [7:0] d;
    logic       v;
    logic       a;
  } vec_t;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out,  data_out1;
  logic       valid_out, valid_out1;
  logic       active,    active1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] prev_d;
  logic       prev_v;
  logic       prev_a;

  vec_t lock_tab[11];
  vec_t brk_tab[9];

  serial_rx_align #(.COM(8'hBC), .COM_LOCK(4)) u_dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  serial_rx_align #(.COM(8'hBC), .COM_LOCK(1)) u_dut1 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in),
    .data_out(data_out1), .valid_out(valid_out1), .active(active1)
  );

  always #5 clk_4f = ~clk_4f;

  function automatic vec_t mk(input logic [7:0] b, input logic [7:0] d, input logic v, input logic a);
    vec_t r;
    r.b = b; r.d = d; r.v = v; r.a = a;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic v, input logic a);
    chk({name, ".data"},   data_out,         d);
    chk({name, ".valid"},  {7'd0, valid_out}, {7'd0, v});
    chk({name, ".active"}, {7'd0, active},    {7'd0, a});
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_4f);
    #1;
  endtask

  // Outputs must hold the previous byte's values until the LSB edge, then show the new ones.
  task automatic send_vec(input string name, input vec_t t);
    for (int i = 7; i >= 0; i--) begin
      send_bit(t.b[i]);
      if (i > 0) chk_out({name, ".hold"}, prev_d, prev_v, prev_a);
      else       chk_out(name, t.d, t.v, t.a);
    end
    prev_d = t.d; prev_v = t.v; prev_a = t.a;
  endtask

  initial begin
    lock_tab[0]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    lock_tab[1]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    lock_tab[2]  = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    lock_tab[3]  = mk(8'hBC, 8'h00, 1'b0, 1'b1);
    lock_tab[4]  = mk(8'hAA, 8'hAA, 1'b1, 1'b1);
    lock_tab[5]  = mk(8'h55, 8'h55, 1'b1, 1'b1);
    lock_tab[6]  = mk(8'hFF, 8'hFF, 1'b1, 1'b1);
    lock_tab[7]  = mk(8'hDD, 8'hDD, 1'b1, 1'b1);
    lock_tab[8]  = mk(8'hBC, 8'hDD, 1'b0, 1'b1);
    lock_tab[9]  = mk(8'hBC, 8'hDD, 1'b0, 1'b1);
    lock_tab[10] = mk(8'hCC, 8'hCC, 1'b1, 1'b1);

    brk_tab[0] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    brk_tab[1] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    brk_tab[2] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    brk_tab[3] = mk(8'h12, 8'h00, 1'b0, 1'b0);
    brk_tab[4] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    brk_tab[5] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    brk_tab[6] = mk(8'hBC, 8'h00, 1'b0, 1'b0);
    brk_tab[7] = mk(8'hBC, 8'h00, 1'b0, 1'b1);
    brk_tab[8] = mk(8'h77, 8'h77, 1'b1, 1'b1);

    // Reset held for 3 cycles with random serial data.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk_out("reset", 8'h00, 1'b0, 1'b0);
    end
    reset = 1'b0;
    prev_d = 8'h00; prev_v = 1'b0; prev_a = 1'b0;

    // Three random lead-in bits; the comma cannot self-overlap so they never fake a match.
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk_out("leadin", 8'h00, 1'b0, 1'b0);
    end
    for (int k = 0; k < 11; k++) send_vec($sformatf("lock[%0d]", k), lock_tab[k]);

    // Reset mid-byte while active.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    send_bit(1'b1);
    chk_out("rst_active", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    prev_d = 8'h00; prev_v = 1'b0; prev_a = 1'b0;

    // Broken comma run, then relock from fresh commas.
    for (int k = 0; k < 9; k++) send_vec($sformatf("brk[%0d]", k), brk_tab[k]);

    // COM_LOCK=1 instance locks on a single comma; the default instance must not.
    reset = 1'b1;
    send_bit(1'b0);
    reset = 1'b0;
    begin
      logic [7:0] com_b;
      logic [7:0] dat_b;
      com_b = 8'hBC;
      dat_b = 8'h15;
      for (int i = 7; i >= 0; i--) send_bit(com_b[i]);
      chk("p1.active",  {7'd0, active1},    8'h01);
      chk("p1.valid",   {7'd0, valid_out1}, 8'h00);
      chk("p1.data",    data_out1,          8'h00);
      chk("p4.noactive", {7'd0, active},    8'h00);
      for (int i = 7; i >= 0; i--) send_bit(dat_b[i]);
      chk("p1.data15",  data_out1,          8'h15);
      chk("p1.valid15", {7'd0, valid_out1}, 8'h01);
      chk("p1.active2", {7'd0, active1},    8'h01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
